// File: rtl/switch_nport.sv
`default_nettype none
// ============================================================================
// Module      : switch_nport
// Description : N-port packet switch. Each input owns a small FIFO; each
//               output owns a holding register fed by a round-robin arbiter.
//               Multicast is expressed as a one-hot target mask; a FIFO head
//               is popped once every targeted output has taken its copy.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_nport #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           in_valid,
  output logic [NUM_PORTS-1:0]           in_ready,
  input  logic [NUM_PORTS*DATA_W-1:0]    in_data,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] in_source,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] in_target,
  output logic [NUM_PORTS-1:0]           in_drop,
  output logic [NUM_PORTS-1:0]           out_valid,
  input  logic [NUM_PORTS-1:0]           out_ready,
  output logic [NUM_PORTS*DATA_W-1:0]    out_data,
  output logic [NUM_PORTS*NUM_PORTS-1:0] out_source
);

  localparam int c_IDX_W = $clog2(NUM_PORTS);
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

  // Per-input FIFO storage and bookkeeping
  logic [DATA_W-1:0]    r_mem_data [NUM_PORTS][FIFO_DEPTH];
  logic [NUM_PORTS-1:0] r_mem_src  [NUM_PORTS][FIFO_DEPTH];
  logic [NUM_PORTS-1:0] r_mem_tgt  [NUM_PORTS][FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wptr     [NUM_PORTS];
  logic [c_PTR_W-1:0]   r_rptr     [NUM_PORTS];
  logic [c_CNT_W-1:0]   r_count    [NUM_PORTS];
  logic [NUM_PORTS-1:0] r_served   [NUM_PORTS];
  logic [NUM_PORTS-1:0] r_in_ready;
  logic [NUM_PORTS-1:0] r_in_drop;

  // Per-output holding registers and round-robin pointers
  logic [c_IDX_W-1:0]   r_rr       [NUM_PORTS];
  logic [NUM_PORTS-1:0] r_out_valid;
  logic [DATA_W-1:0]    r_out_data [NUM_PORTS];
  logic [NUM_PORTS-1:0] r_out_src  [NUM_PORTS];

  logic [NUM_PORTS-1:0] w_push;
  logic [NUM_PORTS-1:0] w_pop;
  logic [NUM_PORTS-1:0] w_drop;
  logic [NUM_PORTS-1:0] w_head_valid;
  logic [NUM_PORTS-1:0] w_out_free;
  logic [NUM_PORTS-1:0] w_grant_vld;
  logic [NUM_PORTS-1:0] w_remaining  [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_gmask      [NUM_PORTS];
  logic [c_IDX_W-1:0]   w_grant_idx  [NUM_PORTS];
  logic [c_IDX_W-1:0]   w_rr_next    [NUM_PORTS];
  logic [c_CNT_W-1:0]   w_count_next [NUM_PORTS];

  // Head-of-line view and input handshake decode
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_head_valid[i] = (r_count[i] != '0);
      w_remaining[i]  = w_head_valid[i] ? (r_mem_tgt[i][r_rptr[i]] & ~r_served[i]) : '0;
      w_push[i] = in_valid[i] & r_in_ready[i] & (|in_target[i*NUM_PORTS +: NUM_PORTS]);
      w_drop[i] = in_valid[i] & r_in_ready[i] & ~(|in_target[i*NUM_PORTS +: NUM_PORTS]);
    end
  end

  // Round-robin arbitration per output, only when its register can take a packet
  always_comb begin
    logic [c_IDX_W:0]   sum;
    logic [c_IDX_W-1:0] cand;
    sum  = '0;
    cand = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      w_out_free[j]  = ~r_out_valid[j] | out_ready[j];
      w_grant_vld[j] = 1'b0;
      w_grant_idx[j] = '0;
      w_rr_next[j]   = r_rr[j];
      for (int k = 0; k < NUM_PORTS; k++) begin
        sum = {1'b0, r_rr[j]} + (c_IDX_W+1)'(k);
        if (sum >= (c_IDX_W+1)'(NUM_PORTS)) begin
          sum = sum - (c_IDX_W+1)'(NUM_PORTS);
        end
        cand = sum[c_IDX_W-1:0];
        if (w_out_free[j] && !w_grant_vld[j] && w_remaining[cand][j]) begin
          w_grant_vld[j] = 1'b1;
          w_grant_idx[j] = cand;
          w_rr_next[j]   = (cand == c_IDX_W'(NUM_PORTS-1)) ? '0 : cand + 1'b1;
        end
      end
    end
  end

  // Collect grants per input; pop once no targeted output is left waiting
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_gmask[i] = '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (w_grant_vld[j] && (w_grant_idx[j] == c_IDX_W'(i))) begin
          w_gmask[i][j] = 1'b1;
        end
      end
      w_pop[i] = (|w_gmask[i]) && ((w_remaining[i] & ~w_gmask[i]) == '0);
      w_count_next[i] = r_count[i];
      if (w_push[i] && !w_pop[i]) begin
        w_count_next[i] = r_count[i] + 1'b1;
      end else if (!w_push[i] && w_pop[i]) begin
        w_count_next[i] = r_count[i] - 1'b1;
      end
    end
  end

  // FIFO pointers, occupancy, served masks and the registered input handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_wptr[i]   <= '0;
        r_rptr[i]   <= '0;
        r_count[i]  <= '0;
        r_served[i] <= '0;
      end
      r_in_ready <= '0;
      r_in_drop  <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_push[i]) begin
          r_wptr[i] <= r_wptr[i] + 1'b1;
        end
        if (w_pop[i]) begin
          r_rptr[i]   <= r_rptr[i] + 1'b1;
          r_served[i] <= '0;
        end else begin
          r_served[i] <= r_served[i] | w_gmask[i];
        end
        r_count[i]    <= w_count_next[i];
        r_in_ready[i] <= (w_count_next[i] < c_CNT_W'(FIFO_DEPTH));
      end
      r_in_drop <= w_drop;
    end
  end

  // FIFO payload storage; contents are meaningless while the count says empty
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_push[i]) begin
        r_mem_data[i][r_wptr[i]] <= in_data[i*DATA_W +: DATA_W];
        r_mem_src[i][r_wptr[i]]  <= in_source[i*NUM_PORTS +: NUM_PORTS];
        r_mem_tgt[i][r_wptr[i]]  <= in_target[i*NUM_PORTS +: NUM_PORTS];
      end
    end
  end

  // Output holding registers: reload on grant, otherwise clear when consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        r_rr[j]       <= '0;
        r_out_data[j] <= '0;
        r_out_src[j]  <= '0;
      end
      r_out_valid <= '0;
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (w_grant_vld[j]) begin
          r_out_valid[j] <= 1'b1;
          r_out_data[j]  <= r_mem_data[w_grant_idx[j]][r_rptr[w_grant_idx[j]]];
          r_out_src[j]   <= r_mem_src[w_grant_idx[j]][r_rptr[w_grant_idx[j]]];
          r_rr[j]        <= w_rr_next[j];
        end else if (out_ready[j]) begin
          r_out_valid[j] <= 1'b0;
        end
      end
    end
  end

  generate
    for (genvar j = 0; j < NUM_PORTS; j++) begin : g_pack
      assign out_data[j*DATA_W +: DATA_W]         = r_out_data[j];
      assign out_source[j*NUM_PORTS +: NUM_PORTS] = r_out_src[j];
    end
  endgenerate

  assign in_ready  = r_in_ready;
  assign in_drop   = r_in_drop;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire
